// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing types and default 640x480@60 constants
package vga_pkg;

  // One axis of raster timing, in pixels (horizontal) or lines (vertical)
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam bit      VGA_640X480_POL = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered blank/sync decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_640X480_H.active,
  parameter int FP     = VGA_640X480_H.fp,
  parameter int SYNC   = VGA_640X480_H.sync,
  parameter int BP     = VGA_640X480_H.bp,
  parameter bit POL    = VGA_640X480_POL,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         blank,
  output logic         sync
);

  localparam logic [W-1:0] L_LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] L_ACTIVE     = W'(ACTIVE);
  localparam logic [W-1:0] L_SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] L_SYNC_END   = W'(ACTIVE + FP + SYNC);

  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_param_check
    $error("vga_axis_counter: ACTIVE/FP/SYNC/BP must all be non-zero");
  end

  logic [W-1:0] r_cnt;
  logic         r_blank;
  logic         r_sync;
  logic [W-1:0] w_next;

  // wrap is the current count being the last one, so the other axis can step on the same edge
  assign wrap   = (r_cnt == L_LAST);
  assign w_next = wrap ? '0 : r_cnt + 1'b1;

  // Flags are decoded from the next count so they line up with cnt on the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_blank <= 1'b0;
      r_sync  <= ~POL;
    end else if (en) begin
      r_cnt   <= w_next;
      r_blank <= (w_next >= L_ACTIVE);
      r_sync  <= ((w_next >= L_SYNC_START) && (w_next < L_SYNC_END)) ? POL : ~POL;
    end
  end

  assign cnt   = r_cnt;
  assign blank = r_blank;
  assign sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator producing x/y, blank, sync and frame_start
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640X480_H.active,
  parameter int H_FP     = VGA_640X480_H.fp,
  parameter int H_SYNC   = VGA_640X480_H.sync,
  parameter int H_BP     = VGA_640X480_H.bp,
  parameter int V_ACTIVE = VGA_640X480_V.active,
  parameter int V_FP     = VGA_640X480_V.fp,
  parameter int V_SYNC   = VGA_640X480_V.sync,
  parameter int V_BP     = VGA_640X480_V.bp,
  parameter bit SYNC_POL = VGA_640X480_POL,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hblank,
  output logic           vblank,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start
);

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_v_en;
  logic r_frame_start;

  // Lines advance only on the pixel strobe that ends the current line
  assign w_v_en = pix_en & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL)
  ) u_h (
    .clk   (clk),
    .rst   (rst),
    .en    (pix_en),
    .cnt   (x),
    .wrap  (w_h_wrap),
    .blank (hblank),
    .sync  (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL)
  ) u_v (
    .clk   (clk),
    .rst   (rst),
    .en    (w_v_en),
    .cnt   (y),
    .wrap  (w_v_wrap),
    .blank (vblank),
    .sync  (vsync)
  );

  // Pulse for one clk alongside the counters landing on (0,0) from the last pixel of a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_en & w_h_wrap & w_v_wrap;
    end
  end

  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and small timings)
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pe_d = 1'b0;
  logic pe_s = 1'b0;

  logic [9:0] dd_x;
  logic [9:0] dd_y;
  logic       dd_hb, dd_vb, dd_hs, dd_vs, dd_fs;
  logic [3:0] ds_x;
  logic [2:0] ds_y;
  logic       ds_hb, ds_vb, ds_hs, ds_vs, ds_fs;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int dcnt = 0;

  // Model state: linear pixel index within the frame, and expected frame_start
  int nd = 0;
  int ns = 0;
  bit fsd = 1'b0;
  bit fss = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen u_dflt (
    .clk (clk), .rst (rst), .pix_en (pe_d),
    .x (dd_x), .y (dd_y), .hblank (dd_hb), .vblank (dd_vb),
    .hsync (dd_hs), .vsync (dd_vs), .frame_start (dd_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) u_small (
    .clk (clk), .rst (rst), .pix_en (pe_s),
    .x (ds_x), .y (ds_y), .hblank (ds_hb), .vblank (ds_vb),
    .hsync (ds_hs), .vsync (ds_vs), .frame_start (ds_fs)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the pixel index with plain arithmetic
  task automatic cmp_dut(input string tag, input int n, input bit fs_e,
                         input int ha, input int hf, input int hs, input int hb,
                         input int va, input int vf, input int vs, input int vb,
                         input int ax, input int ay, input bit ahb, input bit avb,
                         input bit ahs, input bit avs, input bit afs);
    int ht, ex, ey;
    ht = ha + hf + hs + hb;
    ex = n % ht;
    ey = n / ht;
    chk({tag, ".x"}, ax, ex);
    chk({tag, ".y"}, ay, ey);
    chk({tag, ".hblank"}, ahb, ex >= ha);
    chk({tag, ".vblank"}, avb, ey >= va);
    chk({tag, ".hsync"}, ahs, !(ex >= ha + hf && ex < ha + hf + hs));
    chk({tag, ".vsync"}, avs, !(ey >= va + vf && ey < va + vf + vs));
    chk({tag, ".frame_start"}, afs, fs_e);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      nd = 0; ns = 0; fsd = 1'b0; fss = 1'b0;
    end else begin
      if (pe_d) begin nd = (nd + 1) % (800 * 525); fsd = (nd == 0); end
      else fsd = 1'b0;
      if (pe_s) begin ns = (ns + 1) % (14 * 7); fss = (ns == 0); end
      else fss = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("dflt", nd, fsd, 640, 16, 96, 48, 480, 10, 2, 33,
              dd_x, dd_y, dd_hb, dd_vb, dd_hs, dd_vs, dd_fs);
      cmp_dut("small", ns, fss, 8, 2, 3, 1, 4, 1, 1, 1,
              ds_x, ds_y, ds_hb, ds_vb, ds_hs, ds_vs, ds_fs);
    end
  end

  task automatic tick(input bit r, input bit s);
    @(negedge clk);
    rst  = r;
    pe_s = s;
    pe_d = (dcnt % 4 == 3);
    dcnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fs_cnt, vis, vs_low, wraps, t0, t1, hs_low, prev_x;

    repeat (3) tick(1'b1, 1'b1);
    chk_en = 1'b1;
    chk("rst.dflt.x", dd_x, 0);        chk("rst.dflt.y", dd_y, 0);
    chk("rst.dflt.hblank", dd_hb, 0);  chk("rst.dflt.vblank", dd_vb, 0);
    chk("rst.dflt.hsync", dd_hs, 1);   chk("rst.dflt.vsync", dd_vs, 1);
    chk("rst.dflt.fs", dd_fs, 0);
    chk("rst.small.x", ds_x, 0);       chk("rst.small.hsync", ds_hs, 1);

    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 1'b1);
      if (i == 7)  chk("small.hblank@7", ds_hb, 0);
      if (i == 8)  begin chk("small.x@8", ds_x, 8); chk("small.hblank@8", ds_hb, 1); end
      if (i == 9)  chk("small.hsync@9", ds_hs, 1);
      if (i == 10) chk("small.hsync@10", ds_hs, 0);
      if (i == 12) chk("small.hsync@12", ds_hs, 0);
      if (i == 13) begin chk("small.hsync@13", ds_hs, 1); chk("small.y@13", ds_y, 0); end
      if (i == 14) begin chk("small.x@14", ds_x, 0); chk("small.y@14", ds_y, 1); end
    end

    fs_cnt = 0; vis = 0; vs_low = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1'b0, 1'b1);
      if (ds_fs) begin
        fs_cnt++;
        chk("small.fs_at_origin", {ds_x, 1'b0, ds_y}, 0);
      end
      if (!ds_hb && !ds_vb) vis++;
      if (!ds_vs) vs_low++;
    end
    chk("small.frame_starts", fs_cnt, 1);
    chk("small.visible", vis, 32);
    chk("small.vsync_low", vs_low, 14);

    repeat (3) tick(1'b0, 1'b0);
    chk("hold.x", ds_x, 0);
    chk("hold.y", ds_y, 1);
    chk("hold.fs", ds_fs, 0);

    tick(1'b1, 1'b1);
    repeat (33) tick(1'b0, 1'b1);
    chk("mid.x", ds_x, 5);
    chk("mid.y", ds_y, 2);
    tick(1'b1, 1'b1);
    chk("midrst.x", ds_x, 0);
    chk("midrst.y", ds_y, 0);
    chk("midrst.fs", ds_fs, 0);
    repeat (20) tick(1'b0, 1'b1);
    chk("resume.x", ds_x, 6);
    chk("resume.y", ds_y, 1);

    wraps = 0; t0 = 0; t1 = 0; hs_low = 0; prev_x = dd_x;
    for (int i = 0; i < 10000 && wraps < 2; i++) begin
      tick(1'b0, 1'b1);
      if (prev_x == 799 && dd_x == 0) begin
        wraps++;
        if (wraps == 1) t0 = i; else t1 = i;
      end
      if (wraps == 1 && !dd_hs) hs_low++;
      prev_x = dd_x;
    end
    chk("dflt.line_wraps", wraps, 2);
    chk("dflt.line_clks", t1 - t0, 3200);
    chk("dflt.hsync_low_clks", hs_low, 384);
    chk("dflt.y_after_2_lines", dd_y, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
